// File: rtl/operand_pipe_mux.sv
// -----------------------------------------------------------------------------
// operand_pipe_mux
//
// Purpose:
//   Registered D->E operand stage for the CPU datapath. It captures the decode
//   slot (PC, regfile reads, immediate, indices and operand selects) into an
//   E-stage register with stall/flush control. It forwards M/W-stage results
//   into the ALU, jump-base and store-data operands, and it owns the fetch PC,
//   including the taken-branch redirect.
//
// Port summary:
//   i_clk, i_rst          clock, synchronous active-high reset
//   i_stall, i_flush      hold / bubble control for PC and E register
//   i_d_*                 decode-stage instruction fields
//   i_m_*, i_w_*          M/W-stage write-back info used for forwarding
//   i_jb_taken, i_jb_out  E-stage branch/jump resolution and target
//   o_pc                  fetch PC (register)
//   o_e_valid             E-stage register valid
//   o_alu_operand1/2      ALU operands (forwarded)
//   o_jb_operand1         jump-base operand (forwarded)
//   o_e_store_data        forwarded rs2 (store data)
//   o_jb                  redirect taken this cycle
// -----------------------------------------------------------------------------
module operand_pipe_mux #(
    parameter int unsigned       XLEN     = 32,
    parameter int unsigned       REG_AW   = 5,
    parameter logic [XLEN-1:0]   RESET_PC = {XLEN{1'b0}},
    parameter logic [XLEN-1:0]   PC_STEP  = XLEN'(32'd4)
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_stall,
    input  logic              i_flush,
    input  logic              i_d_valid,
    input  logic [XLEN-1:0]   i_d_pc,
    input  logic [XLEN-1:0]   i_d_rs1_data,
    input  logic [XLEN-1:0]   i_d_rs2_data,
    input  logic [XLEN-1:0]   i_d_imm,
    input  logic [REG_AW-1:0] i_d_rs1_index,
    input  logic [REG_AW-1:0] i_d_rs2_index,
    input  logic              i_d_alu_op1_sel,
    input  logic              i_d_alu_op2_sel,
    input  logic              i_d_jb_op1_sel,
    input  logic              i_m_reg_w,
    input  logic [REG_AW-1:0] i_m_rd_index,
    input  logic [XLEN-1:0]   i_m_alu_out,
    input  logic              i_w_reg_w,
    input  logic [REG_AW-1:0] i_w_rd_index,
    input  logic [XLEN-1:0]   i_w_wb_data,
    input  logic              i_jb_taken,
    input  logic [XLEN-1:0]   i_jb_out,
    output logic [XLEN-1:0]   o_pc,
    output logic              o_e_valid,
    output logic [XLEN-1:0]   o_alu_operand1,
    output logic [XLEN-1:0]   o_alu_operand2,
    output logic [XLEN-1:0]   o_jb_operand1,
    output logic [XLEN-1:0]   o_e_store_data,
    output logic              o_jb
);

    // E-stage register fields
    logic              r_e_valid;
    logic [XLEN-1:0]   r_e_pc;
    logic [XLEN-1:0]   r_e_rs1_data;
    logic [XLEN-1:0]   r_e_rs2_data;
    logic [XLEN-1:0]   r_e_imm;
    logic [REG_AW-1:0] r_e_rs1_index;
    logic [REG_AW-1:0] r_e_rs2_index;
    logic              r_e_alu_op1_sel;
    logic              r_e_alu_op2_sel;
    logic              r_e_jb_op1_sel;

    logic [XLEN-1:0]   r_pc;

    logic [XLEN-1:0]   w_fwd_rs1;
    logic [XLEN-1:0]   w_fwd_rs2;
    logic [XLEN-1:0]   w_jb_target;
    logic              w_jb;

    // Pick the youngest in-flight producer of a source register. M is younger
    // than W so it wins; x0 is hard-wired zero and must never be forwarded.
    function automatic logic [XLEN-1:0] fwd_select(
        input logic [REG_AW-1:0] src_index,
        input logic [XLEN-1:0]   reg_data,
        input logic              m_reg_w,
        input logic [REG_AW-1:0] m_rd_index,
        input logic [XLEN-1:0]   m_alu_out,
        input logic              w_reg_w,
        input logic [REG_AW-1:0] w_rd_index,
        input logic [XLEN-1:0]   w_wb_data
    );
        logic [XLEN-1:0] result;
        if (src_index == {REG_AW{1'b0}}) begin
            result = reg_data;
        end else if (m_reg_w && (m_rd_index == src_index)) begin
            result = m_alu_out;
        end else if (w_reg_w && (w_rd_index == src_index)) begin
            result = w_wb_data;
        end else begin
            result = reg_data;
        end
        return result;
    endfunction

    // E-stage register: reset > flush (bubble) > stall (hold) > capture decode
    always_ff @(posedge i_clk) begin
        if (i_rst || i_flush) begin
            r_e_valid       <= 1'b0;
            r_e_pc          <= {XLEN{1'b0}};
            r_e_rs1_data    <= {XLEN{1'b0}};
            r_e_rs2_data    <= {XLEN{1'b0}};
            r_e_imm         <= {XLEN{1'b0}};
            r_e_rs1_index   <= {REG_AW{1'b0}};
            r_e_rs2_index   <= {REG_AW{1'b0}};
            r_e_alu_op1_sel <= 1'b0;
            r_e_alu_op2_sel <= 1'b0;
            r_e_jb_op1_sel  <= 1'b0;
        end else if (!i_stall) begin
            r_e_valid       <= i_d_valid;
            r_e_pc          <= i_d_pc;
            r_e_rs1_data    <= i_d_rs1_data;
            r_e_rs2_data    <= i_d_rs2_data;
            r_e_imm         <= i_d_imm;
            r_e_rs1_index   <= i_d_rs1_index;
            r_e_rs2_index   <= i_d_rs2_index;
            r_e_alu_op1_sel <= i_d_alu_op1_sel;
            r_e_alu_op2_sel <= i_d_alu_op2_sel;
            r_e_jb_op1_sel  <= i_d_jb_op1_sel;
        end
    end

    // Redirect only when the E slot holds a real instruction; target is
    // halfword aligned by clearing bit 0.
    assign w_jb        = i_jb_taken && r_e_valid;
    assign w_jb_target = i_jb_out & {{(XLEN-1){1'b1}}, 1'b0};

    // Fetch PC: reset > redirect (overrides stall) > stall (hold) > sequential
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_pc <= RESET_PC;
        end else if (w_jb) begin
            r_pc <= w_jb_target;
        end else if (!i_stall) begin
            r_pc <= r_pc + PC_STEP;
        end
    end

    // Operand forwarding and selection from the E register
    always_comb begin
        w_fwd_rs1 = fwd_select(r_e_rs1_index, r_e_rs1_data,
                               i_m_reg_w, i_m_rd_index, i_m_alu_out,
                               i_w_reg_w, i_w_rd_index, i_w_wb_data);
        w_fwd_rs2 = fwd_select(r_e_rs2_index, r_e_rs2_data,
                               i_m_reg_w, i_m_rd_index, i_m_alu_out,
                               i_w_reg_w, i_w_rd_index, i_w_wb_data);
    end

    assign o_alu_operand1 = r_e_alu_op1_sel ? w_fwd_rs1 : r_e_pc;
    assign o_alu_operand2 = r_e_alu_op2_sel ? w_fwd_rs2 : r_e_imm;
    assign o_jb_operand1  = r_e_jb_op1_sel  ? w_fwd_rs1 : r_e_pc;
    assign o_e_store_data = w_fwd_rs2;
    assign o_pc           = r_pc;
    assign o_e_valid      = r_e_valid;
    assign o_jb           = w_jb;

endmodule

// File: tb/tb_operand_pipe_mux.sv
module tb_operand_pipe_mux;

    localparam int unsigned XLEN   = 32;
    localparam int unsigned REG_AW = 5;
    localparam logic [31:0] RST_PC = 32'h0000_0100;

    typedef struct {
        logic        rst, stall, flush, d_valid;
        logic [31:0] d_pc, rs1, rs2, imm;
        logic [4:0]  i1, i2;
        logic        s1, s2, sj;
        logic        mw;
        logic [4:0]  md;
        logic [31:0] mo;
        logic        ww;
        logic [4:0]  wd;
        logic [31:0] wo;
        logic        jt;
        logic [31:0] jo;
    } in_t;

    typedef struct {
        string       name;
        in_t         in;
        logic [31:0] pc, a1, a2, j1, sd;
        logic        ev, jb;
    } vec_t;

    // model E-stage contents
    typedef struct {
        logic        valid;
        logic [31:0] pc, rs1, rs2, imm;
        logic [4:0]  i1, i2;
        logic        s1, s2, sj;
    } e_t;

    logic        clk;
    in_t         cur;
    logic [31:0] o_pc, o_a1, o_a2, o_j1, o_sd;
    logic        o_ev, o_jb;

    int total = 0;
    int bad   = 0;

    logic [31:0] m_pc;
    e_t          m_e;
    vec_t        vecs[$];

    operand_pipe_mux #(
        .XLEN(XLEN), .REG_AW(REG_AW), .RESET_PC(RST_PC), .PC_STEP(32'd4)
    ) dut (
        .i_clk(clk), .i_rst(cur.rst), .i_stall(cur.stall), .i_flush(cur.flush),
        .i_d_valid(cur.d_valid), .i_d_pc(cur.d_pc),
        .i_d_rs1_data(cur.rs1), .i_d_rs2_data(cur.rs2), .i_d_imm(cur.imm),
        .i_d_rs1_index(cur.i1), .i_d_rs2_index(cur.i2),
        .i_d_alu_op1_sel(cur.s1), .i_d_alu_op2_sel(cur.s2), .i_d_jb_op1_sel(cur.sj),
        .i_m_reg_w(cur.mw), .i_m_rd_index(cur.md), .i_m_alu_out(cur.mo),
        .i_w_reg_w(cur.ww), .i_w_rd_index(cur.wd), .i_w_wb_data(cur.wo),
        .i_jb_taken(cur.jt), .i_jb_out(cur.jo),
        .o_pc(o_pc), .o_e_valid(o_ev), .o_alu_operand1(o_a1), .o_alu_operand2(o_a2),
        .o_jb_operand1(o_j1), .o_e_store_data(o_sd), .o_jb(o_jb)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Value a source register sees in E: newest producer wins, x0 is constant.
    function automatic logic [31:0] src_value(input logic [4:0] idx, input logic [31:0] regval);
        if (idx == 5'd0)                      return regval;
        if (cur.mw && cur.md == idx)          return cur.mo;
        if (cur.ww && cur.wd == idx)          return cur.wo;
        return regval;
    endfunction

    // Advance the reference model across one clock edge using the current inputs.
    task automatic model_edge();
        e_t   nxt_e;
        logic redirect;
        redirect = cur.jt && m_e.valid;
        nxt_e = m_e;
        if (cur.rst || cur.flush) begin
            nxt_e = '{default: '0};
        end else if (!cur.stall) begin
            nxt_e = '{valid: cur.d_valid, pc: cur.d_pc, rs1: cur.rs1, rs2: cur.rs2,
                      imm: cur.imm, i1: cur.i1, i2: cur.i2, s1: cur.s1, s2: cur.s2,
                      sj: cur.sj};
        end
        if (cur.rst)          m_pc = RST_PC;
        else if (redirect)    m_pc = cur.jo - (cur.jo % 32'd2);
        else if (!cur.stall)  m_pc = m_pc + 32'd4;
        m_e = nxt_e;
    endtask

    task automatic tick();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic add(input string nm, input in_t t, input logic [31:0] pc, input logic ev,
                       input logic [31:0] a1, input logic [31:0] a2, input logic [31:0] j1,
                       input logic [31:0] sd, input logic jb);
        vec_t v;
        v.name = nm; v.in = t; v.pc = pc; v.ev = ev;
        v.a1 = a1; v.a2 = a2; v.j1 = j1; v.sd = sd; v.jb = jb;
        vecs.push_back(v);
    endtask

    initial begin
        in_t t;
        logic [31:0] e_a1, e_a2, e_j1, e_sd;

        cur  = '{default: '0};
        m_pc = 32'd0;
        m_e  = '{default: '0};

        // ---- directed table: inputs held for one edge, outputs checked after it
        t = '{default: '0}; t.rst = 1'b1;
        add("reset0", t, 32'h100, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0);
        t.stall = 1'b1; t.flush = 1'b1; t.d_valid = 1'b1; t.d_pc = 32'h55; t.rs1 = 32'h9;
        add("reset_wins", t, 32'h100, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0);
        t = '{default: '0};
        add("seq104", t, 32'h104, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0);
        add("seq108", t, 32'h108, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0);
        t.d_valid = 1'b1; t.d_pc = 32'h40; t.rs1 = 32'h11; t.rs2 = 32'h22; t.imm = 32'h7;
        t.i1 = 5'd5; t.i2 = 5'd6;
        add("load_pc_imm", t, 32'h10C, 1'b1, 32'h40, 32'h7, 32'h40, 32'h22, 1'b0);
        t.s1 = 1'b1; t.sj = 1'b1;
        t.mw = 1'b1; t.md = 5'd5; t.mo = 32'hAA; t.ww = 1'b1; t.wd = 5'd5; t.wo = 32'hBB;
        add("fwd_m_prio", t, 32'h110, 1'b1, 32'hAA, 32'h7, 32'hAA, 32'h22, 1'b0);
        t.mw = 1'b0;
        add("fwd_w", t, 32'h114, 1'b1, 32'hBB, 32'h7, 32'hBB, 32'h22, 1'b0);
        t.mw = 1'b1; t.i1 = 5'd0; t.md = 5'd0; t.wd = 5'd0;
        add("fwd_x0", t, 32'h118, 1'b1, 32'h11, 32'h7, 32'h11, 32'h22, 1'b0);
        t.i1 = 5'd5; t.md = 5'd6; t.mo = 32'hCC; t.wd = 5'd5; t.s2 = 1'b1;
        add("fwd_rs2", t, 32'h11C, 1'b1, 32'hBB, 32'hCC, 32'hBB, 32'hCC, 1'b0);
        t.stall = 1'b1; t.d_pc = 32'h99; t.rs1 = 32'h77; t.d_valid = 1'b0; t.i1 = 5'd0;
        add("stall1", t, 32'h11C, 1'b1, 32'hBB, 32'hCC, 32'hBB, 32'hCC, 1'b0);
        add("stall2", t, 32'h11C, 1'b1, 32'hBB, 32'hCC, 32'hBB, 32'hCC, 1'b0);
        add("stall3", t, 32'h11C, 1'b1, 32'hBB, 32'hCC, 32'hBB, 32'hCC, 1'b0);
        t.flush = 1'b1;
        add("stall_flush", t, 32'h11C, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0);
        t = '{default: '0}; t.d_valid = 1'b1; t.d_pc = 32'h300;
        add("load_br", t, 32'h120, 1'b1, 32'h300, 32'h0, 32'h300, 32'h0, 1'b0);
        t.stall = 1'b1; t.jt = 1'b1; t.jo = 32'h203;
        add("redirect_stall", t, 32'h202, 1'b1, 32'h300, 32'h0, 32'h300, 32'h0, 1'b1);
        t.stall = 1'b0; t.flush = 1'b1; t.jt = 1'b0;
        add("flush_only", t, 32'h206, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0);
        t.flush = 1'b0; t.stall = 1'b1; t.jt = 1'b1;
        add("redirect_invalid", t, 32'h206, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0);
        t.stall = 1'b0; t.jt = 1'b0; t.d_pc = 32'h500;
        add("load_wrap", t, 32'h20A, 1'b1, 32'h500, 32'h0, 32'h500, 32'h0, 1'b0);
        t.jt = 1'b1; t.jo = 32'hFFFF_FFFD;
        add("redirect_top", t, 32'hFFFF_FFFC, 1'b1, 32'h500, 32'h0, 32'h500, 32'h0, 1'b1);
        t.jt = 1'b0;
        add("pc_wrap", t, 32'h0, 1'b1, 32'h500, 32'h0, 32'h500, 32'h0, 1'b0);

        for (int i = 0; i < vecs.size(); i++) begin
            cur = vecs[i].in;
            tick();
            chk({vecs[i].name, ".pc"},  o_pc, vecs[i].pc);
            chk({vecs[i].name, ".ev"},  {31'd0, o_ev}, {31'd0, vecs[i].ev});
            chk({vecs[i].name, ".a1"},  o_a1, vecs[i].a1);
            chk({vecs[i].name, ".a2"},  o_a2, vecs[i].a2);
            chk({vecs[i].name, ".j1"},  o_j1, vecs[i].j1);
            chk({vecs[i].name, ".sd"},  o_sd, vecs[i].sd);
            chk({vecs[i].name, ".jb"},  {31'd0, o_jb}, {31'd0, vecs[i].jb});
        end

        // ---- randomized run against the reference model
        for (int n = 0; n < 400; n++) begin
            cur.rst     = ($urandom_range(0, 49) == 0);
            cur.stall   = ($urandom_range(0, 3) == 0);
            cur.flush   = ($urandom_range(0, 6) == 0);
            cur.d_valid = $urandom_range(0, 1);
            cur.d_pc    = $urandom;
            cur.rs1     = $urandom;
            cur.rs2     = $urandom;
            cur.imm     = $urandom;
            cur.i1      = 5'($urandom_range(0, 3));
            cur.i2      = 5'($urandom_range(0, 3));
            cur.s1      = $urandom_range(0, 1);
            cur.s2      = $urandom_range(0, 1);
            cur.sj      = $urandom_range(0, 1);
            cur.mw      = $urandom_range(0, 1);
            cur.md      = 5'($urandom_range(0, 3));
            cur.mo      = $urandom;
            cur.ww      = $urandom_range(0, 1);
            cur.wd      = 5'($urandom_range(0, 3));
            cur.wo      = $urandom;
            cur.jt      = ($urandom_range(0, 2) == 0);
            cur.jo      = $urandom;
            tick();
            e_sd = src_value(m_e.i2, m_e.rs2);
            e_a1 = m_e.s1 ? src_value(m_e.i1, m_e.rs1) : m_e.pc;
            e_a2 = m_e.s2 ? e_sd : m_e.imm;
            e_j1 = m_e.sj ? src_value(m_e.i1, m_e.rs1) : m_e.pc;
            chk("rnd.pc", o_pc, m_pc);
            chk("rnd.ev", {31'd0, o_ev}, {31'd0, m_e.valid});
            chk("rnd.a1", o_a1, e_a1);
            chk("rnd.a2", o_a2, e_a2);
            chk("rnd.j1", o_j1, e_j1);
            chk("rnd.sd", o_sd, e_sd);
            chk("rnd.jb", {31'd0, o_jb}, {31'd0, (cur.jt && m_e.valid)});
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
